inst_fetch_stage: RTL

//   Fetch stage directly downstream of the per-core PC counter. Drives the counter's

---
 rtl/inst_fetch_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: drives the PC counter enable, reads instruction memory at the
// current PC and buffers (pc, inst) pairs in a 2-entry FIFO toward decode.
module inst_fetch_stage #(
    parameter int INST_ADDR_WIDTH = 9,
    parameter int INST_WIDTH      = 32,
    parameter int STOP_AT_END     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_i,
    input  logic [INST_ADDR_WIDTH-1:0] pc_in_i,
    output logic                       pc_en_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    output logic                       imem_rd_en_o,
    input  logic [INST_WIDTH-1:0]      imem_rdata_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [INST_ADDR_WIDTH-1:0] out_pc_o,
    output logic [INST_WIDTH-1:0]      out_inst_o,
    output logic                       done_o
);
    localparam int W  = INST_ADDR_WIDTH;
    localparam int IW = INST_WIDTH;

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [IW-1:0] inst;
    } entry_t;

    entry_t       ent0_q, ent1_q, ent0_d, ent1_d, new_ent;
    logic [1:0]   occ_q, occ_d;
    logic         infl_q;
    logic [W-1:0] pc_q;
    logic         done_q, done_d;
    logic         pop, push, issue;
    logic [2:0]   pending;

    assign out_valid_o = (occ_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign push        = infl_q;
    assign new_ent     = {pc_q, imem_rdata_i};

    // Slots committed after this edge; a same-cycle pop frees one for back-to-back issue.
    assign pending = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue   = run_i & ~done_q & ~reset & (pending <= 3'd1);

    assign pc_en_o      = issue;
    assign imem_rd_en_o = issue;
    assign imem_addr_o  = pc_in_i;
    assign out_pc_o     = ent0_q.pc;
    assign out_inst_o   = ent0_q.inst;
    assign done_o       = done_q;

    assign done_d = done_q | ((STOP_AT_END != 0) & issue & (&pc_in_i));

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = new_ent;
                else               ent1_d = new_ent;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = new_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
            infl_q <= 1'b0;
            pc_q   <= '0;
            done_q <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
            infl_q <= issue;
            if (issue) pc_q <= pc_in_i;
            done_q <= done_d;
        end
    end
endmodule
